operand_stack_nbit: RTL and testbench
=====================================

# operand_stack_nbit

Parametrised LIFO operand stack. It is the next generation of the single n-bit load/clear operand register used by the calculator datapath. The stack holds up to DEPTH words of WIDTH bits and exposes the top two entries directly as ALU operands. It supports push, pop and a single-cycle "reduce" that replaces the top two operands with an ALU result, for RPN-style evaluation. Illegal commands are rejected without changing state and are recorded in a sticky error flag.

## Interface
- WIDTH, 16, data word width in bits (≥1).
- DEPTH, 4, number of stack entries (≥2).
- Derived, not overridable: CW = $clog2(DEPTH+1), the width of the count output.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- clear  in  1  synchronous clear; same effect as rst.
- push  in  1  push D onto the stack.
- pop  in  1  discard the top entry.
- reduce  in  1  pop two entries, then push D (ALU result).
- D  in  WIDTH  write data; sampled at the edge where push or reduce is accepted.
- top  out  WIDTH  top-of-stack entry; 0 when count=0.
- next  out  WIDTH  entry directly below top; 0 when count<2.
- count  out  CW  number of valid entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- err  out  1  sticky illegal-command flag.

## Operation
- Storage: DEPTH×WIDTH entries, index 0 is the bottom. Valid entries are 0..count-1.
- Every entry at or above count holds 0 at all times. Any operation that vacates an entry writes 0 to it.
- Priority per edge: rst > clear > command decode.
- rst or clear:
  - all entries and count are set to 0;
  - err is set to 0;
  - push, pop and reduce are ignored that cycle.
- Command decode (at most one of push, pop, reduce per cycle):
  - none asserted: hold all state.
  - push with count<DEPTH: entry[count]←D, count+1.
  - pop with count≥1: entry[count-1]←0, count-1.
  - reduce with count≥2: entry[count-2]←D, entry[count-1]←0, count-1.
- Illegal cycles leave entries and count unchanged and set err to 1. A cycle is illegal if:
  - two or more of push, pop, reduce are asserted;
  - push is asserted while full;
  - pop is asserted while empty;
  - reduce is asserted while count<2.
- err stays 1 until rst or clear. Legal commands continue to execute while err=1.
- top and next are decoded combinationally from storage and count: top=entry[count-1], next=entry[count-2]. Each is 0 when the corresponding entry does not exist.
- empty and full are decoded combinationally from count.

## Timing
- Reset values: top=0, next=0, count=0, empty=1, full=0, err=0.
- Command latency: 1 cycle. An operation accepted at edge k is visible on all outputs immediately after edge k. There is no additional read latency.
- D is captured only on accepted push/reduce edges; its value is don't-care otherwise.
- Back-to-back commands on consecutive cycles are supported at full rate, with no bubbles.
- top and next are valid in the same cycle that count changes. An ALU driven from top and next may present its result on D and assert reduce in the very next cycle.
- rst or clear asserted mid-sequence wins at that edge, regardless of the pending command.
- No throttling handshake exists. Upstream is responsible for using full and empty; violations only set err.

## Test plan
- Reset: hold rst for 2 cycles with push=1, D=0xFFFF -> count=0, empty=1, full=0, top=0x0000, next=0x0000, err=0.
- Push/reduce: push 0x0003, then push 0x0005 -> count=2, top=0x0005, next=0x0003. Then reduce with D=0x0008 -> count=1, top=0x0008, next=0x0000, err=0.
- Overflow: push 0x0001, 0x0002, 0x0003, 0x0004 -> full=1, count=4, top=0x0004, next=0x0003. Then push 0x0005 -> err=1, count=4, top=0x0004. Then pop -> count=3, top=0x0003, err remains 1.
- Underflow: pop on an empty stack -> err=1, count=0. After clear, push 0x00AA, then reduce -> err=1, count=1, top=0x00AA. Popping the 0x00AA entry and re-pushing 0x0000 leaves top=0x0000 and next=0x0000 (vacated entries read back as zero).
- Conflicting commands: with count=2, assert push=1 and pop=1 together -> no change to count or entries, err=1. Assert push and reduce together -> same result.
- Clear priority: with count=3 and err=1, assert clear with push=1 and D=0x1234 -> count=0, err=0, top=0x0000. In the next cycle, push 0x1234 -> count=1, top=0x1234.

Source files
------------

// File: rtl/operand_stack_nbit.sv
`default_nettype none
// ============================================================================
// Module   : operand_stack_nbit
// Purpose  : Parametrised LIFO operand stack for the calculator datapath.
//            Holds up to DEPTH words of WIDTH bits. The top two entries are
//            presented directly as ALU operands (top / next). Supports push,
//            pop and a single-cycle reduce (pop two, push ALU result).
//            Illegal commands leave state untouched and set a sticky err.
// Ports    : clk, rst (sync, active-high), clear (sync clear, same as rst)
//            push / pop / reduce : one-hot command strobes
//            D      [WIDTH-1:0]  : write data for push / reduce
//            top    [WIDTH-1:0]  : top-of-stack entry, 0 when empty
//            next   [WIDTH-1:0]  : entry below top, 0 when count<2
//            count  [CW-1:0]     : number of valid entries, 0..DEPTH
//            empty, full         : decoded from count
//            err                 : sticky illegal-command flag
// Revision : 1.0 - initial release
// ============================================================================
module operand_stack_nbit #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic             reduce,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] top,
    output logic [WIDTH-1:0] next,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             err
);

    localparam logic [CW-1:0] c_one   = CW'(1);
    localparam logic [CW-1:0] c_two   = CW'(2);
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             err_q;
    logic             err_d;

    logic [1:0]       w_cmd_cnt;
    logic             w_full;
    logic             w_empty;

    assign w_cmd_cnt = {1'b0, push} + {1'b0, pop} + {1'b0, reduce};
    assign w_full    = (count_q == c_depth);
    assign w_empty   = (count_q == '0);

    // Next-state decode. Every vacated slot is explicitly zeroed so that
    // all entries at or above count always read as zero.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stack_d[i] = stack_q[i];
        end
        count_d = count_q;
        err_d   = err_q;

        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_d[i] = '0;
            end
            count_d = '0;
            err_d   = 1'b0;
        end else if (w_cmd_cnt > 2'd1) begin
            err_d = 1'b1;
        end else if (push) begin
            if (w_full) begin
                err_d = 1'b1;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (i == int'(count_q)) stack_d[i] = D;
                end
                count_d = count_q + c_one;
            end
        end else if (pop) begin
            if (w_empty) begin
                err_d = 1'b1;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (i == int'(count_q) - 1) stack_d[i] = '0;
                end
                count_d = count_q - c_one;
            end
        end else if (reduce) begin
            if (count_q < c_two) begin
                err_d = 1'b1;
            end else begin
                // Result lands where the lower operand was; the old top slot
                // is vacated.
                for (int i = 0; i < DEPTH; i++) begin
                    if (i == int'(count_q) - 2) stack_d[i] = D;
                    if (i == int'(count_q) - 1) stack_d[i] = '0;
                end
                count_d = count_q - c_one;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= stack_d[i];
            end
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Operand read-out: combinational so an ALU sees the new operands in the
    // same cycle count changes.
    always_comb begin
        top  = '0;
        next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i + 1 == int'(count_q)) top  = stack_q[i];
            if (i + 2 == int'(count_q)) next = stack_q[i];
        end
    end

    assign count = count_q;
    assign empty = w_empty;
    assign full  = w_full;
    assign err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_stack_nbit.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_stack_nbit
// Purpose  : Directed self-checking bench for operand_stack_nbit
//            (WIDTH=16, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_stack_nbit;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clear = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             reduce = 1'b0;
    logic [WIDTH-1:0] D = '0;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] next;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             err;

    int n_assert = 0;
    int n_fail   = 0;

    operand_stack_nbit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .push   (push),
        .pop    (pop),
        .reduce (reduce),
        .D      (D),
        .top    (top),
        .next   (next),
        .count  (count),
        .empty  (empty),
        .full   (full),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one command for one edge, then sample 1 time unit after the edge.
    task automatic cmd(input logic c, input logic p, input logic o,
                       input logic r, input logic [WIDTH-1:0] d);
        clear  = c;
        push   = p;
        pop    = o;
        reduce = r;
        D      = d;
        @(posedge clk);
        #1;
        clear  = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;
        reduce = 1'b0;
        D      = 16'hDEAD;
    endtask

    task automatic chk_state(input string tag, input logic [CW-1:0] e_cnt,
                             input logic [WIDTH-1:0] e_top, input logic [WIDTH-1:0] e_next,
                             input logic e_err);
        chk({tag, ".count"}, 32'(count), 32'(e_cnt));
        chk({tag, ".top"},   32'(top),   32'(e_top));
        chk({tag, ".next"},  32'(next),  32'(e_next));
        chk({tag, ".err"},   32'(err),   32'(e_err));
    endtask

    initial begin
        // Reset held two cycles while push is asserted: push must be ignored.
        rst  = 1'b1;
        push = 1'b1;
        D    = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        push = 1'b0;
        chk_state("reset", 0, 16'h0000, 16'h0000, 1'b0);
        chk("reset.empty", 32'(empty), 1);
        chk("reset.full",  32'(full),  0);

        // Push / reduce
        cmd(0, 1, 0, 0, 16'h0003);
        cmd(0, 1, 0, 0, 16'h0005);
        chk_state("push2", 2, 16'h0005, 16'h0003, 1'b0);
        chk("push2.empty", 32'(empty), 0);
        cmd(0, 0, 0, 1, 16'h0008);
        chk_state("reduce", 1, 16'h0008, 16'h0000, 1'b0);

        // Overflow
        cmd(1, 0, 0, 0, 16'h0000);
        cmd(0, 1, 0, 0, 16'h0001);
        cmd(0, 1, 0, 0, 16'h0002);
        cmd(0, 1, 0, 0, 16'h0003);
        cmd(0, 1, 0, 0, 16'h0004);
        chk_state("fill", 4, 16'h0004, 16'h0003, 1'b0);
        chk("fill.full", 32'(full), 1);
        cmd(0, 1, 0, 0, 16'h0005);
        chk_state("ovf", 4, 16'h0004, 16'h0003, 1'b1);
        cmd(0, 0, 1, 0, 16'h0000);
        chk_state("pop_after_err", 3, 16'h0003, 16'h0002, 1'b1);
        chk("pop_after_err.full", 32'(full), 0);

        // Clear priority: count=3, err=1, clear with push pending
        cmd(1, 1, 0, 0, 16'h1234);
        chk_state("clear_prio", 0, 16'h0000, 16'h0000, 1'b0);
        chk("clear_prio.empty", 32'(empty), 1);
        cmd(0, 1, 0, 0, 16'h1234);
        chk_state("push_after_clear", 1, 16'h1234, 16'h0000, 1'b0);

        // Underflow
        cmd(1, 0, 0, 0, 16'h0000);
        cmd(0, 0, 1, 0, 16'h0000);
        chk_state("pop_empty", 0, 16'h0000, 16'h0000, 1'b1);
        cmd(1, 0, 0, 0, 16'h0000);
        cmd(0, 1, 0, 0, 16'h00AA);
        cmd(0, 0, 0, 1, 16'h0055);
        chk_state("reduce_one", 1, 16'h00AA, 16'h0000, 1'b1);
        cmd(0, 0, 1, 0, 16'h0000);
        chk_state("pop_aa", 0, 16'h0000, 16'h0000, 1'b1);
        cmd(0, 1, 0, 0, 16'h0000);
        chk_state("repush_zero", 1, 16'h0000, 16'h0000, 1'b1);

        // Vacated slot above a reduce must read back as zero
        cmd(1, 0, 0, 0, 16'h0000);
        cmd(0, 1, 0, 0, 16'h0002);
        cmd(0, 1, 0, 0, 16'h0003);
        cmd(0, 1, 0, 0, 16'h0004);
        cmd(0, 0, 0, 1, 16'h0007);
        chk_state("reduce3", 2, 16'h0007, 16'h0002, 1'b0);
        cmd(0, 1, 0, 0, 16'h0000);
        chk_state("vacated_zero", 3, 16'h0000, 16'h0007, 1'b0);

        // Conflicting commands
        cmd(1, 0, 0, 0, 16'h0000);
        cmd(0, 1, 0, 0, 16'h0011);
        cmd(0, 1, 0, 0, 16'h0022);
        cmd(0, 1, 1, 0, 16'h0099);
        chk_state("push_pop", 2, 16'h0022, 16'h0011, 1'b1);
        cmd(1, 0, 0, 0, 16'h0000);
        cmd(0, 1, 0, 0, 16'h0011);
        cmd(0, 1, 0, 0, 16'h0022);
        cmd(0, 1, 0, 1, 16'h0099);
        chk_state("push_reduce", 2, 16'h0022, 16'h0011, 1'b1);
        cmd(0, 0, 1, 1, 16'h0099);
        chk_state("pop_reduce", 2, 16'h0022, 16'h0011, 1'b1);

        // Back-to-back reduce at full rate, result on the following edge
        cmd(0, 1, 0, 0, 16'h0033);
        cmd(0, 0, 0, 1, 16'h0055);
        cmd(0, 0, 0, 1, 16'h0066);
        chk_state("b2b_reduce", 1, 16'h0066, 16'h0000, 1'b1);

        // rst mid-sequence wins over a pending command
        rst  = 1'b1;
        push = 1'b1;
        D    = 16'h7777;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        push = 1'b0;
        chk_state("rst_mid", 0, 16'h0000, 16'h0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
